fm_cfg_ctrl: RTL

UART-driven configuration controller for the FM/IQ modulator datapath. It parses framed command bytes from the host UART receiver and holds shadow copies of the modulator's configuration: LO tuning word, FM deviation gain, and enable/mute control. New values are committed to the NCO/baseband datapath glitch-free on a phase-accumulator wrap. Each frame is answered with an ACK/NAK byte through the UART transmitter handshake.

---
 rtl/fm_ctrl_pkg.sv | 22 ++
 rtl/fm_ctrl_commit.sv | 78 +++++++
 rtl/fm_cfg_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fm_ctrl_pkg.sv
// Shared constants and parser state encoding for the FM modulator config controller.
package fm_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    localparam logic [7:0] REG_TW    = 8'h00;
    localparam logic [7:0] REG_GAIN  = 8'h01;
    localparam logic [7:0] REG_CTRL  = 8'h02;

    localparam int FRAME_LEN = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_RESP
    } state_t;

endpackage

// File: rtl/fm_ctrl_commit.sv
// Shadow/active configuration registers: writes land in shadows and are promoted
// on NCO phase wrap, except a control write that disables, which applies at once.
module fm_ctrl_commit
    import fm_ctrl_pkg::*;
#(
    parameter int TW_WIDTH   = 32,
    parameter int GAIN_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  phase_wrap,
    output logic [TW_WIDTH-1:0]   tuning_word,
    output logic [GAIN_WIDTH-1:0] fm_gain,
    output logic                  enable,
    output logic                  mute,
    output logic                  cfg_update
);

    logic [TW_WIDTH-1:0]   sh_tw;
    logic [GAIN_WIDTH-1:0] sh_gain;
    logic [1:0]            sh_ctrl;
    logic                  pend_tw, pend_gain, pend_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_tw       <= '0;
            sh_gain     <= '0;
            sh_ctrl     <= '0;
            pend_tw     <= 1'b0;
            pend_gain   <= 1'b0;
            pend_ctrl   <= 1'b0;
            tuning_word <= '0;
            fm_gain     <= '0;
            enable      <= 1'b0;
            mute        <= 1'b1;
            cfg_update  <= 1'b0;
        end else begin
            cfg_update <= 1'b0;
            if (phase_wrap) begin
                if (pend_tw)   tuning_word <= sh_tw;
                if (pend_gain) fm_gain     <= sh_gain;
                if (pend_ctrl) {mute, enable} <= sh_ctrl;
                if (pend_tw || pend_gain || pend_ctrl) cfg_update <= 1'b1;
                pend_tw   <= 1'b0;
                pend_gain <= 1'b0;
                pend_ctrl <= 1'b0;
            end
            // A write coinciding with a wrap stays pending for the next wrap.
            if (wr_en) begin
                case (wr_addr)
                    REG_TW: begin
                        sh_tw   <= wr_data[TW_WIDTH-1:0];
                        pend_tw <= 1'b1;
                    end
                    REG_GAIN: begin
                        sh_gain   <= wr_data[GAIN_WIDTH-1:0];
                        pend_gain <= 1'b1;
                    end
                    REG_CTRL: begin
                        sh_ctrl <= wr_data[1:0];
                        if (!wr_data[0]) begin
                            {mute, enable} <= wr_data[1:0];
                            pend_ctrl      <= 1'b0;
                            cfg_update     <= 1'b1;
                        end else begin
                            pend_ctrl <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/fm_cfg_ctrl.sv
// UART frame parser, inter-byte timeout and ACK/NAK responder for the FM modulator config.
// Define FM_CTRL_READBACK_EN to enable register reads (ADDR bit7) answered with 4 data bytes.
module fm_cfg_ctrl
    import fm_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TW_WIDTH       = 32,
    parameter int GAIN_WIDTH     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_stb,
    input  logic [7:0]            i_rx_data,
    output logic                  o_tx_stb,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_busy,
    input  logic                  i_phase_wrap,
    output logic [TW_WIDTH-1:0]   o_tuning_word,
    output logic [GAIN_WIDTH-1:0] o_fm_gain,
    output logic                  o_enable,
    output logic                  o_mute,
    output logic                  o_cfg_update,
    output logic [7:0]            o_err_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t           state;
    logic [1:0]       byte_cnt;
    logic [7:0]       addr, csum;
    logic [31:0]      data;
    logic [TMO_W-1:0] tmo_cnt;
    logic             in_frame, tmo_hit, frame_end, frame_ok, addr_ok, is_read, wr_en, err_inc;

`ifdef FM_CTRL_READBACK_EN
    logic [2:0]  resp_left;
    logic [31:0] resp_word, rd_word;

    assign is_read = addr[7];
    assign addr_ok = addr[6:0] <= 7'(REG_CTRL);

    always_comb begin
        rd_word = '0;
        case (addr[1:0])
            2'd0:    rd_word = 32'(o_tuning_word);
            2'd1:    rd_word = 32'(o_fm_gain);
            default: rd_word = {30'd0, o_mute, o_enable};
        endcase
    end
`else
    assign is_read = 1'b0;
    assign addr_ok = addr <= REG_CTRL;
`endif

    assign in_frame  = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CSUM);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign tmo_hit   = in_frame && !i_rx_stb && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign frame_end = (state == ST_CSUM) && i_rx_stb;
    assign frame_ok  = frame_end && (i_rx_data == csum) && addr_ok;
    assign wr_en     = frame_ok && !is_read;
    assign err_inc   = (frame_end && !frame_ok) || ((state == ST_RESP) && i_rx_stb) || tmo_hit;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                   tmo_cnt <= '0;
        else if (i_rx_stb || !in_frame) tmo_cnt <= '0;
        else                            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            addr      <= '0;
            csum      <= '0;
            data      <= '0;
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
            o_err_cnt <= '0;
`ifdef FM_CTRL_READBACK_EN
            resp_left <= '0;
            resp_word <= '0;
`endif
        end else begin
            if (err_inc && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
            if (tmo_hit) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (i_rx_stb && i_rx_data == SYNC_BYTE) state <= ST_ADDR;
                    ST_ADDR: if (i_rx_stb) begin
                        addr     <= i_rx_data;
                        csum     <= i_rx_data;
                        byte_cnt <= '0;
                        state    <= ST_DATA;
                    end
                    ST_DATA: if (i_rx_stb) begin
                        data     <= {data[23:0], i_rx_data};
                        csum     <= csum ^ i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) state <= ST_CSUM;
                    end
                    ST_CSUM: if (i_rx_stb) begin
                        state     <= ST_RESP;
                        o_tx_stb  <= 1'b1;
                        o_tx_data <= frame_ok ? ACK_BYTE : NAK_BYTE;
`ifdef FM_CTRL_READBACK_EN
                        resp_left <= (frame_ok && is_read) ? 3'd4 : 3'd0;
                        resp_word <= rd_word;
`endif
                    end
                    ST_RESP: if (o_tx_stb && !i_tx_busy) begin
`ifdef FM_CTRL_READBACK_EN
                        if (resp_left != 3'd0) begin
                            o_tx_data <= resp_word[31:24];
                            resp_word <= {resp_word[23:0], 8'h00};
                            resp_left <= resp_left - 3'd1;
                        end else begin
                            o_tx_stb <= 1'b0;
                            state    <= ST_IDLE;
                        end
`else
                        o_tx_stb <= 1'b0;
                        state    <= ST_IDLE;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    fm_ctrl_commit #(
        .TW_WIDTH   (TW_WIDTH),
        .GAIN_WIDTH (GAIN_WIDTH)
    ) u_commit (
        .clk         (i_clk),
        .rst_n       (i_reset),
        .wr_en       (wr_en),
        .wr_addr     (addr),
        .wr_data     (data),
        .phase_wrap  (i_phase_wrap),
        .tuning_word (o_tuning_word),
        .fm_gain     (o_fm_gain),
        .enable      (o_enable),
        .mute        (o_mute),
        .cfg_update  (o_cfg_update)
    );

endmodule
